fcpu_io_axi_responder: RTL
==========================

Name: fcpu_io_axi_responder

Overview:
AXI4 responder (slave) for the fcpu I/O initiator port. It terminates fcpu's io_aw/w/b/ar/r channels and bridges them to the byte-stream handshakes of serial_interface. Written data bytes go to the UART transmitter. Read data comes from a receive FIFO filled by the UART receiver, or from a status register. It sits in fcpu_top between fcpu_inst and serial_if_inst, on clk (ui_clk).

Parameters:
ID_W, 4, AXI ID width.
ADDR_W, 32, AXI address width.
RX_DEPTH, 16, receive FIFO entries; power of two, at least 2.
DATA_OFS, 32'h0, byte offset of the data register.
STAT_OFS, 32'h4, byte offset of the status register.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-high.
io_awid/io_awaddr/io_awlen  in  ID_W/ADDR_W/8  write address; only addr[3:0] is decoded.
io_awsize/io_awburst  in  3/2  accepted and ignored; every beat is one byte.
io_awvalid/io_awready  in/out  1/1  AW handshake.
io_wdata/io_wstrb/io_wlast  in  8/1/1  write data beat.
io_wvalid/io_wready  in/out  1/1  W handshake.
io_bid/io_bresp  out  ID_W/2  write response.
io_bvalid/io_bready  out/in  1/1  B handshake.
io_arid/io_araddr/io_arlen  in  ID_W/ADDR_W/8  read address.
io_arsize/io_arburst  in  3/2  ignored.
io_arvalid/io_arready  in/out  1/1  AR handshake.
io_rid/io_rdata/io_rresp/io_rlast  out  ID_W/8/2/1  read data beat.
io_rvalid/io_rready  out/in  1/1  R handshake.
tx_data/tx_valid/tx_ready  out/out/in  8/1/1  byte stream to serial_interface i_*.
rx_data/rx_valid/rx_ready  in/in/out  8/1/1  byte stream from serial_interface o_*.

Behaviour:
- Reset: all FSMs go to IDLE and the FIFO is emptied.
  - Outputs after reset: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, tx_valid=0, rx_ready=1.
  - bid/rid/bresp/rresp/rdata/rlast are 0.
- Reset mid-burst abandons the transaction. No response is issued. Buffered RX bytes are lost.
- Decode: addr[3:0]==DATA_OFS[3:0] selects DATA; ==STAT_OFS[3:0] selects STAT; anything else is BAD.

Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
- W_IDLE: awready=1. On AW handshake, latch id and decode, then go to W_DATA.
- W_DATA, target DATA:
  - tx_valid = wvalid & wstrb; tx_data = wdata; wready = wstrb ? tx_ready : 1.
  - Zero-strobe beats are consumed without transmitting.
- W_DATA, target STAT or BAD: wready=1 and the data is discarded.
- A beat with wlast=1 completes the burst and moves to W_RESP. awlen is not used to terminate.
- W_RESP: bvalid=1 and bid = latched id. bresp=OKAY for DATA, SLVERR for STAT and BAD. Hold until bready, then return to W_IDLE.

Read FSM: R_IDLE -> R_DATA -> R_IDLE.
- R_IDLE: arready=1. On AR handshake, latch id, decode, and set the beat counter to arlen.
- R_DATA, target DATA: rvalid = FIFO not empty; rdata = FIFO head. The FIFO pops on rvalid & rready. The read blocks until a byte arrives.
- R_DATA, target STAT: rvalid=1; rdata = {6'b0, tx_ready, fifo_nonempty}.
- R_DATA, target BAD: rvalid=1; rdata=0; rresp=SLVERR.
- Other targets return rresp=OKAY. rlast = (counter==0).
- Each handshake decrements the counter. The handshake on the last beat returns to R_IDLE.
- Read and write FSMs are independent and may run concurrently.

RX FIFO:
- rx_ready = !full. A push happens on rx_valid & rx_ready.
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- When full, rx_ready=0, so incoming bytes are back-pressured and none are dropped.
- Pointers are log2(RX_DEPTH) bits and wrap naturally. The occupancy counter is log2(RX_DEPTH)+1 bits.
- Latency: a byte pushed in cycle N is readable as rdata in cycle N+1.

Decomposition:
- Add to fcpu_pkg:
  - resp_t enum: OKAY=2'b00, SLVERR=2'b10.
  - io_target_t enum: DATA, STAT, BAD.
  - wstate_t and rstate_t enums.
- Sub-module: fcpu_io_rx_fifo, a synchronous FIFO with push/pop/full/empty/head.

Test Plan:
- Single write of 0x41 to addr 0x0 (len=0, wlast=1) with tx_ready=1 -> tx_valid pulses with tx_data=0x41, then bvalid with bresp=OKAY and the matching bid.
- Write burst of len=3 (0x10..0x13) with tx_ready toggling every other cycle -> four bytes in order, wready tracks tx_ready, exactly one B response.
- Push 0x55 and 0xAA on rx, then read len=1 at 0x0 with rid=5 -> rdata 0x55 then 0xAA, rlast on the 2nd beat, rid=5, FIFO empty afterwards.
- Read at 0x0 with an empty FIFO -> rvalid stays 0 until a byte is pushed 10 cycles later, then rvalid=1 with that byte on the next cycle.
- Push 17 bytes with RX_DEPTH=16 -> rx_ready drops after the 16th. Read 16 + 1 -> all 17 bytes return in order with none lost.
- Read STAT at 0x4 with FIFO empty and tx_ready=1 -> rdata=0x02. Write to 0x8 -> data discarded, bresp=SLVERR. Assert rst mid-read-burst -> rvalid=0 next cycle and arready=1.

Source files
------------

// File: rtl/fcpu_pkg.sv
// Shared types for the fcpu I/O responder: response codes, decode targets and FSM states.
package fcpu_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        DATA,
        STAT,
        BAD
    } io_target_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_t;

    // Only the low address nibble selects a register; everything else aliases.
    function automatic io_target_t decode_target(
        input logic [3:0] addr,
        input logic [3:0] data_ofs,
        input logic [3:0] stat_ofs
    );
        if (addr == data_ofs) return DATA;
        if (addr == stat_ofs) return STAT;
        return BAD;
    endfunction

endpackage

// File: rtl/fcpu_io_rx_fifo.sv
// Synchronous byte FIFO for UART receive data; head is visible the cycle after a push.
module fcpu_io_rx_fifo
    import fcpu_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fcpu_io_axi_responder.sv
// AXI4 responder for the fcpu I/O port: writes stream bytes to the UART transmitter,
// reads return bytes from the receive FIFO or a status register.
module fcpu_io_axi_responder
    import fcpu_pkg::*;
#(
    parameter int          ID_W     = 4,
    parameter int          ADDR_W   = 32,
    parameter int          RX_DEPTH = 16,
    parameter logic [31:0] DATA_OFS = 32'h0,
    parameter logic [31:0] STAT_OFS = 32'h4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ID_W-1:0]   io_awid,
    input  logic [ADDR_W-1:0] io_awaddr,
    input  logic [7:0]        io_awlen,
    input  logic [2:0]        io_awsize,
    input  logic [1:0]        io_awburst,
    input  logic              io_awvalid,
    output logic              io_awready,

    input  logic [7:0]        io_wdata,
    input  logic              io_wstrb,
    input  logic              io_wlast,
    input  logic              io_wvalid,
    output logic              io_wready,

    output logic [ID_W-1:0]   io_bid,
    output logic [1:0]        io_bresp,
    output logic              io_bvalid,
    input  logic              io_bready,

    input  logic [ID_W-1:0]   io_arid,
    input  logic [ADDR_W-1:0] io_araddr,
    input  logic [7:0]        io_arlen,
    input  logic [2:0]        io_arsize,
    input  logic [1:0]        io_arburst,
    input  logic              io_arvalid,
    output logic              io_arready,

    output logic [ID_W-1:0]   io_rid,
    output logic [7:0]        io_rdata,
    output logic [1:0]        io_rresp,
    output logic              io_rlast,
    output logic              io_rvalid,
    input  logic              io_rready,

    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,

    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready
);

    wstate_t          wstate_q;
    io_target_t       wtgt_q;
    logic [ID_W-1:0]  bid_q;

    rstate_t          rstate_q;
    io_target_t       rtgt_q;
    logic [ID_W-1:0]  rid_q;
    logic [7:0]       rcnt_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_head;
    logic             fifo_pop;
    logic             w_beat;
    logic             r_beat;

    // Burst length and size fields are not needed: wlast ends writes, every beat is one byte.
    logic unused_inputs;
    assign unused_inputs = ^{io_awaddr[ADDR_W-1:4], io_awlen, io_awsize, io_awburst,
                             io_araddr[ADDR_W-1:4], io_arsize, io_arburst};

    fcpu_io_rx_fifo #(
        .DEPTH (RX_DEPTH),
        .W     (8)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rx_valid),
        .din_i   (rx_data),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    assign rx_ready = !fifo_full;

    always_comb begin
        io_awready = (wstate_q == W_IDLE);
        io_wready  = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = io_wdata;
        if (wstate_q == W_DATA) begin
            if (wtgt_q == DATA) begin
                tx_valid  = io_wvalid && io_wstrb;
                io_wready = io_wstrb ? tx_ready : 1'b1;
            end else begin
                io_wready = 1'b1;
            end
        end
        io_bvalid = (wstate_q == W_RESP);
        io_bid    = bid_q;
        io_bresp  = ((wstate_q == W_RESP) && (wtgt_q != DATA)) ? SLVERR : OKAY;
    end

    assign w_beat = io_wvalid && io_wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q <= W_IDLE;
            wtgt_q   <= DATA;
            bid_q    <= '0;
        end else begin
            case (wstate_q)
                W_IDLE: if (io_awvalid) begin
                    bid_q    <= io_awid;
                    wtgt_q   <= decode_target(io_awaddr[3:0], DATA_OFS[3:0], STAT_OFS[3:0]);
                    wstate_q <= W_DATA;
                end
                W_DATA: if (w_beat && io_wlast) begin
                    wstate_q <= W_RESP;
                end
                W_RESP: if (io_bready) begin
                    wstate_q <= W_IDLE;
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    always_comb begin
        io_arready = (rstate_q == R_IDLE);
        io_rvalid  = 1'b0;
        io_rdata   = 8'h00;
        io_rresp   = OKAY;
        io_rlast   = 1'b0;
        io_rid     = rid_q;
        if (rstate_q == R_DATA) begin
            io_rlast = (rcnt_q == 8'd0);
            case (rtgt_q)
                DATA: begin
                    io_rvalid = !fifo_empty;
                    io_rdata  = fifo_head;
                end
                STAT: begin
                    io_rvalid = 1'b1;
                    io_rdata  = {6'b0, tx_ready, !fifo_empty};
                end
                default: begin
                    io_rvalid = 1'b1;
                    io_rresp  = SLVERR;
                end
            endcase
        end
    end

    assign r_beat   = io_rvalid && io_rready;
    assign fifo_pop = r_beat && (rtgt_q == DATA);

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q <= R_IDLE;
            rtgt_q   <= DATA;
            rid_q    <= '0;
            rcnt_q   <= 8'd0;
        end else begin
            case (rstate_q)
                R_IDLE: if (io_arvalid) begin
                    rid_q    <= io_arid;
                    rtgt_q   <= decode_target(io_araddr[3:0], DATA_OFS[3:0], STAT_OFS[3:0]);
                    rcnt_q   <= io_arlen;
                    rstate_q <= R_DATA;
                end
                R_DATA: if (r_beat) begin
                    if (rcnt_q == 8'd0) begin
                        rstate_q <= R_IDLE;
                    end else begin
                        rcnt_q <= rcnt_q - 8'd1;
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

endmodule
